// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Shared UART definitions: FSM state encoding, frame data   |
// |            width and the cycles-per-bit helper.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

   // Frame phases common to the transmitter and the future receiver
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int DATA_BITS = 8;

   // Clock cycles per serial bit; truncation is the only source of rate error
   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_baud_counter                                         |
// | Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the  |
// |            last cycle of every bit; held at zero while clear is high.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   // CLKS_PER_BIT must be at least 2, so the width is always at least 1
   localparam int                 C_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

   logic [C_CNT_W-1:0] r_count;

   // tick marks the final cycle of a bit so the FSM advances on the boundary
   assign tick = (r_count == C_LAST);

   // Free-running bit timer, restarted by clear and wrapped on each boundary
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + C_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_press_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_press_transmitter                                    |
// | Purpose  : Sends one 8N1 UART frame carrying data for every rising   |
// |            edge of the debounced transmit level. Presses arriving    |
// |            while a frame is on the line are dropped.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_press_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       transmit,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam logic [2:0] C_LAST_BIT   = 3'(DATA_BITS - 1);

   uart_state_t          r_state;
   uart_state_t          w_state_nxt;
   logic                 r_transmit_q;
   logic                 w_start;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_nxt;
   logic                 r_tx;
   logic                 w_tx_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_tick;
   logic                 w_baud_clear;

   // Resetting to 1 means a button already held at reset release is not a press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_transmit_q <= 1'b1;
      end else begin
         r_transmit_q <= transmit;
      end
   end

   assign w_start = transmit & ~r_transmit_q;

   // Timer sits at zero in IDLE so the start bit gets a full period
   assign w_baud_clear = (r_state == IDLE);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_baud_clear),
      .tick    (w_tick)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, shift/bit-index update and registered-output precompute
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      w_done_nxt    = 1'b0;
      w_tx_nxt      = 1'b1;

      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_shift_nxt = data;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_tick) begin
               w_bit_idx_nxt = '0;
               w_state_nxt   = DATA;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
               if (r_bit_idx == C_LAST_BIT) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Line level is derived from where the FSM will be next cycle so tx is a flop
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // Shift register and bit index; data is captured only on an accepted press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_idx <= '0;
      end else begin
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
      end
   end

   // Output registers; reset forces an idle line and abandons any partial frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_press_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_press_transmitter                                 |
// | Purpose  : Self-checking bench for uart_press_transmitter. A frame   |
// |            schedule model predicts tx/busy/done for every cycle.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_press_transmitter;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int CPB      = 10;
   localparam int FRAME    = 10 * CPB;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic       transmit = 1'b0;
   logic [7:0] data     = 8'h00;
   logic       tx;
   logic       busy;
   logic       done;

   int    n_vec = 0;
   int    n_err = 0;
   int    p     = 0;
   string scen  = "init";

   // Model: last sampled transmit, and the schedule of the most recent frame
   bit         m_tq   = 1'b1;
   bit         m_have = 1'b0;
   int         m_s    = 0;
   logic [9:0] m_bits = '1;

   uart_press_transmitter #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .transmit (transmit),
      .data     (data),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s/%s period %0d: got %0h expected %0h", scen, tag, p, obs, exp);
      end
   endtask

   function automatic bit in_frame(input int q);
      return m_have && (q >= m_s) && (q < m_s + FRAME);
   endfunction

   // One clock period: check outputs mid-period, then advance the model at the edge
   task automatic cycle();
      logic etx, ebusy, edone;
      @(negedge clk);
      if (!reset_n) begin
         etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
      end else if (in_frame(p)) begin
         etx = m_bits[(p - m_s) / CPB]; ebusy = 1'b1; edone = 1'b0;
      end else begin
         etx = 1'b1; ebusy = 1'b0; edone = m_have && (p == m_s + FRAME);
      end
      check_val("tx", tx, etx);
      check_val("busy", busy, ebusy);
      check_val("done", done, edone);
      @(posedge clk);
      if (!reset_n) begin
         m_tq   = 1'b1;
         m_have = 1'b0;
      end else begin
         if (transmit && !m_tq && !in_frame(p)) begin
            m_have = 1'b1;
            m_s    = p + 1;
            m_bits = {1'b1, data, 1'b0};
         end
         m_tq = transmit;
      end
      p++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Advance until period target begins, with a cycle budget
   task automatic run_to(input int target);
      for (int i = 0; i < 400 && p < target; i++) cycle();
      check_val("reach", p, target);
   endtask

   initial begin
      // Power-up reset with transmit low, then a quiet line
      scen = "reset";
      #1 reset_n = 1'b0;
      run(3);
      reset_n = 1'b1;
      run(50);

      // A5 frame; data changes mid-frame, held level and a busy re-press are ignored
      scen = "a5";
      data     = 8'hA5;
      transmit = 1'b1;
      cycle();
      data = 8'h3C;
      run(30);
      transmit = 1'b0;
      run(5);
      transmit = 1'b1;
      run(5);
      transmit = 1'b0;

      // Press lands exactly in the done cycle: back-to-back frame of 00
      scen = "b2b";
      run_to(m_s + FRAME);
      data     = 8'h00;
      transmit = 1'b1;
      cycle();
      check_val("b2b_tx_fall", tx, 1'b0);
      run(FRAME + 10);
      transmit = 1'b0;
      run(5);

      // Reset pulse during data bit 3 abandons the frame
      scen = "midrst";
      data     = 8'h5A;
      transmit = 1'b1;
      cycle();
      transmit = 1'b0;
      run_to(m_s + 4 * CPB + 3);
      reset_n = 1'b0;
      #1;
      check_val("async_tx", tx, 1'b1);
      check_val("async_busy", busy, 1'b0);
      run(2);
      reset_n = 1'b1;
      run(20);
      data     = 8'hC3;
      transmit = 1'b1;
      cycle();
      transmit = 1'b0;
      run(FRAME + 5);

      // transmit held high through reset release does not start a frame
      scen = "hold";
      transmit = 1'b1;
      reset_n  = 1'b0;
      run(3);
      reset_n = 1'b1;
      run(30);
      transmit = 1'b0;
      run(2);
      data     = 8'h96;
      transmit = 1'b1;
      run(FRAME + 5);

      // Randomized presses, data churn and occasional resets
      scen = "rand";
      transmit = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) transmit = ~transmit;
         data = 8'($urandom);
         if ($urandom_range(0, 1499) == 0) begin
            reset_n = 1'b0;
            cycle();
            reset_n = 1'b1;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
